// File: rtl/obi_ram_arbiter.sv
// obi_ram_arbiter
//   Two-to-one OBI arbiter sharing a single-port testbench memory between the
//   core's instruction-fetch and data interfaces. One address phase at a time
//   is forwarded to the memory port; in-order responses are routed back to
//   their requester through a small FIFO of requester IDs. Data has priority,
//   and a starvation counter forces an instruction win after STARVE_LIMIT
//   consecutive losses.
//
//   Ports
//     clk_i, rst_i                  clock, synchronous active-high reset
//     instr_*                       instruction OBI port (read-only)
//     data_*                        data OBI port (load/store)
//     mem_*                         memory-side OBI port
//     outstanding_o                 response-routing FIFO occupancy
//     protocol_err_o                sticky: response seen with FIFO empty
module obi_ram_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned STARVE_LIMIT    = 4
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,

    input  logic                                   instr_req_i,
    output logic                                   instr_gnt_o,
    input  logic [31:0]                            instr_addr_i,
    output logic                                   instr_rvalid_o,
    output logic [31:0]                            instr_rdata_o,
    output logic                                   instr_err_o,

    input  logic                                   data_req_i,
    output logic                                   data_gnt_o,
    input  logic [31:0]                            data_addr_i,
    input  logic                                   data_we_i,
    input  logic [3:0]                             data_be_i,
    input  logic [31:0]                            data_wdata_i,
    output logic                                   data_rvalid_o,
    output logic [31:0]                            data_rdata_o,
    output logic                                   data_err_o,

    output logic                                   mem_req_o,
    input  logic                                   mem_gnt_i,
    output logic [31:0]                            mem_addr_o,
    output logic                                   mem_we_o,
    output logic [3:0]                             mem_be_o,
    output logic [31:0]                            mem_wdata_o,
    input  logic                                   mem_rvalid_i,
    input  logic [31:0]                            mem_rdata_i,
    input  logic                                   mem_err_i,

    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
    output logic                                   protocol_err_o
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [STV_W-1:0] STARVE_MAX = STV_W'(STARVE_LIMIT);

    localparam logic ID_I = 1'b0;
    localparam logic ID_D = 1'b1;

    typedef enum logic [1:0] {IDLE, HOLD_I, HOLD_D} state_e;
    typedef enum logic [1:0] {SEL_NONE, SEL_I, SEL_D} sel_e;

    state_e             state_q, state_d;
    sel_e               sel;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic               fifo_q [MAX_OUTSTANDING];
    logic               fifo_d [MAX_OUTSTANDING];
    logic [STV_W-1:0]   starve_q, starve_d;
    logic               perr_q, perr_d;

    logic full, empty, head, push, pop;

    assign full  = (cnt_q == CNT_FULL);
    assign empty = (cnt_q == '0);
    assign head  = fifo_q[rd_ptr_q];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!mem_gnt_i) begin
                    if (sel == SEL_I)      state_d = HOLD_I;
                    else if (sel == SEL_D) state_d = HOLD_D;
                end
            end
            HOLD_I, HOLD_D: if (mem_gnt_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: selection, address-phase mux, grant and response routing
    always_comb begin
        sel = SEL_NONE;
        case (state_q)
            HOLD_I: sel = SEL_I;
            HOLD_D: sel = SEL_D;
            default: begin
                if (!full) begin
                    if (instr_req_i && starve_q == STARVE_MAX) sel = SEL_I;
                    else if (data_req_i)                       sel = SEL_D;
                    else if (instr_req_i)                      sel = SEL_I;
                end
            end
        endcase

        mem_req_o   = (sel != SEL_NONE) && !rst_i;
        mem_addr_o  = '0;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_wdata_o = '0;
        if (sel == SEL_D) begin
            mem_addr_o  = data_addr_i;
            mem_we_o    = data_we_i;
            mem_be_o    = data_be_i;
            mem_wdata_o = data_wdata_i;
        end else if (sel == SEL_I) begin
            mem_addr_o  = instr_addr_i;
            mem_be_o    = '1;
        end

        instr_gnt_o    = mem_gnt_i && mem_req_o && (sel == SEL_I);
        data_gnt_o     = mem_gnt_i && mem_req_o && (sel == SEL_D);
        instr_rvalid_o = pop && (head == ID_I) && !rst_i;
        data_rvalid_o  = pop && (head == ID_D) && !rst_i;
    end

    assign instr_rdata_o  = mem_rdata_i;
    assign instr_err_o    = mem_err_i;
    assign data_rdata_o   = mem_rdata_i;
    assign data_err_o     = mem_err_i;
    assign outstanding_o  = cnt_q;
    assign protocol_err_o = perr_q;

    // FIFO, starvation counter and sticky protocol error
    assign push = mem_req_o && mem_gnt_i;
    assign pop  = mem_rvalid_i && !empty;

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            fifo_d[wr_ptr_q] = (sel == SEL_D) ? ID_D : ID_I;
            wr_ptr_d         = ptr_inc(wr_ptr_q);
        end
        if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase

        starve_d = starve_q;
        if (!instr_req_i || instr_gnt_o) starve_d = '0;
        else if (starve_q != STARVE_MAX) starve_d = starve_q + STV_W'(1);

        perr_d = perr_q || (mem_rvalid_i && empty);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            starve_q <= '0;
            perr_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
            perr_q   <= perr_d;
        end
    end

    // ID storage needs no reset: entries are only read once counted valid
    always_ff @(posedge clk_i) begin
        fifo_q <= fifo_d;
    end

endmodule
